// File: rtl/hwpe_tcdm_responder.sv
// -----------------------------------------------------------------------------
// hwpe_tcdm_responder
//
// Single-port TCDM slave backed by a byte-lane flop/RAM array. It terminates a
// TCDM master port (for example an HWPE streamer) in block-level benches and
// small subsystems. It provides a repeating grant-throttle pattern so that
// master-side stall handling can be exercised. It also flags out-of-range
// accesses and counts granted reads and writes.
//
// Ports
//   clk_i           clock, rising edge
//   clear_i         synchronous active-high reset (memory contents kept)
//   tcdm_req_i      request
//   tcdm_gnt_o      grant (depends on state and clear_i only, never on req)
//   tcdm_add_i      byte address
//   tcdm_wen_i      1 = read, 0 = write
//   tcdm_be_i       byte enables for writes
//   tcdm_data_i     write data
//   tcdm_r_data_o   read data (holds its last value while idle)
//   tcdm_r_valid_o  read response valid, one cycle after each granted read
//   oob_o           sticky: an out-of-range access was granted
//   n_reads_o       granted reads (wraps)
//   n_writes_o      granted writes (wraps)
// -----------------------------------------------------------------------------
module hwpe_tcdm_responder #(
   parameter int unsigned MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned STALL_PERIOD = 1,
   parameter int unsigned STALL_LEN    = 0,
   parameter logic [31:0] OOB_RDATA    = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        clear_i,
   input  logic        tcdm_req_i,
   output logic        tcdm_gnt_o,
   input  logic [31:0] tcdm_add_i,
   input  logic        tcdm_wen_i,
   input  logic [3:0]  tcdm_be_i,
   input  logic [31:0] tcdm_data_i,
   output logic [31:0] tcdm_r_data_o,
   output logic        tcdm_r_valid_o,
   output logic        oob_o,
   output logic [31:0] n_reads_o,
   output logic [31:0] n_writes_o
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          gnt_phase;
   logic [31:0]   offset;
   logic          in_range;
   logic [AW-1:0] idx;
   logic          wr_en, rd_en;
   logic          r_valid_q;
   logic          oob_q;
   logic [31:0]   n_reads_q, n_writes_q;
   logic [31:0]   r_data;
   logic          unused_addr_lsbs;

   // Throttle phase counter: free-runs 0..STALL_PERIOD-1 regardless of req.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(STALL_PERIOD - 1)) begin
         cnt_d = '0;
      end
   end

   // The first STALL_LEN phases of every period are denied.
   if (STALL_LEN == 0) begin : g_no_stall
      assign gnt_phase = 1'b1;
   end else begin : g_stall
      assign gnt_phase = (32'(cnt_q) >= STALL_LEN);
   end

   assign tcdm_gnt_o = ~clear_i & gnt_phase;

   // Address decode. The byte offset within a word is irrelevant.
   assign offset           = tcdm_add_i - BASE_ADDR;
   assign in_range         = (tcdm_add_i >= BASE_ADDR) &&
                             ({2'b00, offset[31:2]} < 32'(MEM_WORDS));
   assign idx              = offset[AW+1:2];
   assign unused_addr_lsbs = ^offset[1:0];

   assign wr_en = tcdm_req_i & tcdm_gnt_o & ~tcdm_wen_i;
   assign rd_en = tcdm_req_i & tcdm_gnt_o &  tcdm_wen_i;

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         cnt_q      <= '0;
         r_valid_q  <= 1'b0;
         oob_q      <= 1'b0;
         n_reads_q  <= '0;
         n_writes_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         r_valid_q <= rd_en;
         if ((rd_en | wr_en) & ~in_range) begin
            oob_q <= 1'b1;
         end
         if (rd_en) begin
            n_reads_q <= n_reads_q + 32'd1;
         end
         if (wr_en) begin
            n_writes_q <= n_writes_q + 32'd1;
         end
      end
   end

   // One independent byte-wide array per lane, so byte-enable writes map onto
   // plain single-write-port memories with a registered read.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [MEM_WORDS];
      logic [7:0] rdata_q;

      always_ff @(posedge clk_i) begin
         if (wr_en && in_range && tcdm_be_i[gi]) begin
            mem_q[idx] <= tcdm_data_i[8*gi +: 8];
         end
      end

      // Only updated by a granted read, so the data holds while idle.
      always_ff @(posedge clk_i) begin
         if (clear_i) begin
            rdata_q <= '0;
         end else if (rd_en) begin
            rdata_q <= in_range ? mem_q[idx] : OOB_RDATA[8*gi +: 8];
         end
      end

      assign r_data[8*gi +: 8] = rdata_q;
   end

   assign tcdm_r_data_o  = r_data;
   assign tcdm_r_valid_o = r_valid_q;
   assign oob_o          = oob_q;
   assign n_reads_o      = n_reads_q;
   assign n_writes_o     = n_writes_q;

endmodule

// File: doc/hwpe_tcdm_responder.md
Name: hwpe_tcdm_responder

Overview:
- Single-port TCDM slave (responder) backed by a flop-array memory.
- Terminates a TCDM master port (req/gnt/add/wen/be/data, r_data/r_valid), e.g. an HWPE streamer load/store unit, in block-level benches and small subsystems.
- Provides parameterised grant throttling, so master-side stall handling can be exercised, plus out-of-range detection and transaction counters.
- Obeys the TCDM rule: r_valid is high exactly one cycle after every granted read.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.
- STALL_PERIOD, 1, length of the grant-throttle pattern in cycles; at least 1.
- STALL_LEN, 0, number of denied cycles at the start of each period; 0 means always grant; must be below STALL_PERIOD.
- OOB_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock, rising edge.
- clear_i  in  1  synchronous active-high reset.
- tcdm_req_i  in  1  request.
- tcdm_gnt_o  out  1  grant.
- tcdm_add_i  in  32  byte address.
- tcdm_wen_i  in  1  1 = read, 0 = write.
- tcdm_be_i  in  4  byte enables for writes.
- tcdm_data_i  in  32  write data.
- tcdm_r_data_o  out  32  read data.
- tcdm_r_valid_o  out  1  read response valid.
- oob_o  out  1  sticky flag: an out-of-range access was granted.
- n_reads_o  out  32  count of granted reads.
- n_writes_o  out  32  count of granted writes.

Behaviour:
- One clock; reset is synchronous and active-high on clear_i.
- Reset values (cycle after clear_i high): tcdm_r_valid_o=0, tcdm_r_data_o=0, oob_o=0, n_reads_o=0, n_writes_o=0, stall counter=0.
- Memory contents are not affected by clear_i and are X until written.
- Stall counter:
  - cnt free-runs 0..STALL_PERIOD-1 and wraps to 0.
  - It advances every cycle clear_i is low, independent of req.
- Grant:
  - tcdm_gnt_o = ~clear_i & (cnt >= STALL_LEN). It is combinational from state only, never from req.
  - gnt may be high with req low; such a cycle is not a transaction.
- Handshake: a transaction occurs on any rising edge with req & gnt. The master holds add/wen/be/data until granted; the responder does not check this.
- Address decode:
  - offset = add - BASE_ADDR; index = offset[31:2]; add[1:0] is ignored.
  - in_range = (add >= BASE_ADDR) & (index < MEM_WORDS).
- Write (wen=0), granted:
  - If in_range, for each byte b with be[b]=1, mem[index] byte b takes data byte b on that edge.
  - If out of range, the write is dropped and oob_o is set.
  - n_writes_o increments.
  - No r_valid is generated.
- Read (wen=1), granted:
  - tcdm_r_valid_o=1 in the next cycle, for exactly one cycle.
  - tcdm_r_data_o in that cycle = mem[index], or OOB_RDATA if out of range (which also sets oob_o).
  - be is ignored on reads. n_reads_o increments.
- Back-to-back:
  - One transaction can complete per granted cycle.
  - Consecutive granted reads give consecutive r_valid pulses.
  - A read granted the cycle after a write to the same word returns the written data (write-then-read ordering).
- Idle: tcdm_r_valid_o=0 and tcdm_r_data_o holds its last value.
- Counters wrap from 2^32-1 to 0. oob_o clears only on clear_i.
- Reset mid-operation: if clear_i is high in a cycle, gnt=0, so no transaction occurs. A read granted in the cycle before clear_i still produces r_valid in the clear cycle, then all state resets.

Test Plan:
1. Write then read with byte enables:
   - Write 32'h1122_3344 to BASE+0x10 with be=4'hF, then write 32'hAAAA_AAAA with be=4'b0101.
   - Read BASE+0x10 -> r_valid one cycle after the read grant, r_data=32'h11AA_33AA; n_writes=2, n_reads=1.
2. Grant throttling:
   - STALL_PERIOD=4, STALL_LEN=3; hold req with a read for 12 cycles after clear.
   - -> gnt high only on cycles 3, 7, 11; exactly 3 r_valid pulses, each on cycles 4, 8, 12.
3. Back-to-back streaming:
   - 8 consecutive reads to words 0..7, pre-written with their index, STALL_LEN=0.
   - -> 8 consecutive r_valid cycles, r_data 0..7 in order.
   - Also: write word 5 = 32'hCAFE_0005 in cycle N, read word 5 in N+1 -> r_data=32'hCAFE_0005.
4. Out of range:
   - Read at BASE+4*MEM_WORDS -> r_data=32'hDEAD_BEEF, oob_o=1 from the next cycle.
   - Write to BASE-4 -> memory unchanged and oob_o stays 1.
   - Assert clear_i -> oob_o=0.
5. Clear mid-operation:
   - A read is granted in cycle N and clear_i is high in N+1.
   - -> r_valid=1 in N+1, gnt=0 in N+1, all counters 0 in N+2, memory contents retained (verify with a read after clear).
6. Protocol monitor: run random req/wen/add traffic for 10k cycles with random stalls -> every granted read is followed by exactly one r_valid; no r_valid without a prior granted read.
